// File: rtl/uart_tx.sv
// uart_tx: FIFO-fed UART transmitter (8N1-style framing, no parity).
// Pulls one word per frame from an upstream FIFO and serializes it
// LSB first between a low start bit and a high stop bit.
module uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy
);

   // Counter widths; keep at least one bit so a degenerate parameter
   // value never yields a zero-width vector.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         baud_cnt, baud_nxt;
   logic [IW-1:0]         bit_idx, bit_nxt;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic                  tx_q, tx_nxt;
   logic                  bit_end;

   // The counter only ever reaches BAUD_LAST, so it never wraps even when
   // CLKS_PER_BIT is a power of two.
   assign bit_end = (baud_cnt == BAUD_LAST);

   // Read strobe is gated by rst_n so no read can be issued while in reset.
   assign fifo_rd_en = rst_n && (state == IDLE) && !fifo_empty;
   assign busy       = (state != IDLE);
   assign tx         = tx_q;

   // Next-state logic; tx_nxt is the line level for the state being
   // entered, so tx is registered yet aligned with the state.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      tx_nxt    = tx_q;
      case (state)
         IDLE: begin
            tx_nxt   = 1'b1;
            baud_nxt = '0;
            if (fifo_rd_en) state_nxt = FETCH;
         end
         FETCH: begin
            // Read data is valid the cycle after the accepted strobe.
            shreg_nxt = fifo_rdata;
            baud_nxt  = '0;
            bit_nxt   = '0;
            tx_nxt    = 1'b0;
            state_nxt = START;
         end
         START: begin
            if (bit_end) begin
               baud_nxt  = '0;
               tx_nxt    = shreg[0];
               state_nxt = DATA;
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_nxt  = '0;
               shreg_nxt = shreg >> 1;
               if (bit_idx == BIT_LAST) begin
                  tx_nxt    = 1'b1;
                  bit_nxt   = '0;
                  state_nxt = STOP;
               end else begin
                  tx_nxt  = shreg_nxt[0];
                  bit_nxt = bit_idx + 1'b1;
               end
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_nxt  = '0;
               tx_nxt    = 1'b1;
               state_nxt = IDLE;
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         default: begin
            baud_nxt  = '0;
            bit_nxt   = '0;
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame and idles the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         shreg    <= shreg_nxt;
         tx_q     <= tx_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx (8 bits / 4 clks per bit) plus a
// second instance at DATA_WIDTH=1, CLKS_PER_BIT=2.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] fifo_rdata;
   logic       fifo_empty;
   logic       fifo_rd_en, tx, busy;
   logic [0:0] p_rdata;
   logic       p_empty;
   logic       p_rd_en, p_tx, p_busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy));

   uart_tx #(.DATA_WIDTH(1), .CLKS_PER_BIT(2)) dut_p (
      .clk(clk), .rst_n(rst_n), .fifo_rdata(p_rdata), .fifo_empty(p_empty),
      .fifo_rd_en(p_rd_en), .tx(p_tx), .busy(p_busy));

   // Drives one word into the 8-bit instance and records the 40 frame cycles.
   // With chaos set, fifo_rdata/fifo_empty are disturbed mid-frame.
   task automatic run_frame(input logic [7:0] w, input bit chaos,
                            output logic [39:0] t, output int bsy,
                            output int rds, output logic rd0, output logic ftx);
      @(negedge clk); fifo_rdata = w; fifo_empty = 1'b0;
      #1 rd0 = fifo_rd_en; bsy = 0; rds = 0;
      @(negedge clk); fifo_empty = 1'b1;
      #1 ftx = tx; bsy += int'(busy); rds += int'(fifo_rd_en);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (chaos && i >= 12 && i < 30) begin
            fifo_rdata = 8'h55; fifo_empty = i[0];
         end else fifo_empty = 1'b1;
         #1 t[i] = tx; bsy += int'(busy); rds += int'(fifo_rd_en);
      end
      @(negedge clk); fifo_empty = 1'b1;
      #1 bsy += int'(busy); rds += int'(fifo_rd_en);
   endtask

   task automatic test_reset();
      fifo_rdata = 8'hA5; fifo_empty = 1'b0; p_rdata = 1'b1; p_empty = 1'b0;
      #12;
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
      checks++; if (p_rd_en !== 1'b0 || p_tx !== 1'b1) begin failures++; $display("FAIL reset_p rd_en=%b tx=%b exp 0/1", p_rd_en, p_tx); end
      @(negedge clk); fifo_empty = 1'b1; p_empty = 1'b1; rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle tx=%b busy=%b exp 1/0", tx, busy); end
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL post_reset_rd_en got=%b exp=0", fifo_rd_en); end
   endtask

   task automatic test_single();
      logic [39:0] t; int bsy, rds, bad; logic rd0, ftx;
      logic [9:0] e = 10'b1101001010;  // start,1,0,1,0,0,1,0,1,stop
      run_frame(8'hA5, 1'b0, t, bsy, rds, rd0, ftx);
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_end_idle tx=%b busy=%b exp 1/0", tx, busy); end
      checks++; if (rd0 !== 1'b1) begin failures++; $display("FAIL single_rd_en got=%b exp=1", rd0); end
      checks++; if (ftx !== 1'b1) begin failures++; $display("FAIL single_fetch_tx got=%b exp=1", ftx); end
      bad = 0;
      for (int i = 0; i < 40; i++) if (t[i] !== e[i/4]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL single_frame_a5 got=%h exp_bits=%b bad=%0d", t, e, bad); end
      checks++; if (bsy != 41) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=41", bsy); end
      checks++; if (rds != 0) begin failures++; $display("FAIL single_extra_reads got=%0d exp=0", rds); end
   endtask

   task automatic test_rdata_change();
      logic [39:0] t; int bsy, rds, bad; logic rd0, ftx;
      logic [9:0] e = 10'b1100000010;  // 0x81 framed
      run_frame(8'h81, 1'b1, t, bsy, rds, rd0, ftx);
      bad = 0;
      for (int i = 0; i < 40; i++) if (t[i] !== e[i/4]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL rdata_change_frame got=%h exp_bits=%b bad=%0d", t, e, bad); end
      checks++; if (rds != 0) begin failures++; $display("FAIL rdata_change_reads got=%0d exp=0", rds); end
      checks++; if (bsy != 41) begin failures++; $display("FAIL rdata_change_busy got=%0d exp=41", bsy); end
   endtask

   task automatic test_idle_empty();
      int rds = 0, txlow = 0, bsy = 0;
      fifo_empty = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         rds += int'(fifo_rd_en); txlow += int'(tx !== 1'b1); bsy += int'(busy);
      end
      checks++; if (rds != 0) begin failures++; $display("FAIL empty_rd_en got=%0d exp=0", rds); end
      checks++; if (txlow != 0) begin failures++; $display("FAIL empty_tx_low got=%0d exp=0", txlow); end
      checks++; if (bsy != 0) begin failures++; $display("FAIL empty_busy got=%0d exp=0", bsy); end
   endtask

   task automatic test_reset_mid();
      logic [39:0] t; int bsy, rds, bad; logic rd0, ftx;
      logic [9:0] e = 10'b1100101100;  // 0x96 framed
      @(negedge clk); fifo_rdata = 8'h3C; fifo_empty = 1'b0;
      @(negedge clk); fifo_empty = 1'b1;
      repeat (18) @(negedge clk);      // second cycle of data bit 3
      #1;
      checks++; if (tx !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre_reset tx=%b busy=%b exp 1/1", tx, busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mid_reset_tx got=%b exp=1", tx); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin failures++; $display("FAIL mid_no_resume busy=%b rd_en=%b exp 0/0", busy, fifo_rd_en); end
      run_frame(8'h96, 1'b0, t, bsy, rds, rd0, ftx);
      bad = 0;
      for (int i = 0; i < 40; i++) if (t[i] !== e[i/4]) bad++;
      checks++; if (rd0 !== 1'b1) begin failures++; $display("FAIL mid_next_rd_en got=%b exp=1", rd0); end
      checks++; if (bad != 0) begin failures++; $display("FAIL mid_next_frame got=%h exp_bits=%b bad=%0d", t, e, bad); end
      checks++; if (bsy != 41) begin failures++; $display("FAIL mid_next_busy got=%0d exp=41", bsy); end
   endtask

   task automatic test_back_to_back();
      logic [95:0] t; int reads = 0, r0 = -1, r1 = -1, bad0 = 0, bad1 = 0;
      logic [9:0] e0 = 10'b1000000000;  // 0x00 framed
      logic [9:0] e1 = 10'b1111111110;  // 0xFF framed
      for (int k = 0; k < 96; k++) begin
         @(negedge clk);
         fifo_empty = (reads >= 2);
         fifo_rdata = (reads <= 1) ? 8'h00 : 8'hFF;
         #1 t[k] = tx;
         if (fifo_rd_en) begin
            if (reads == 0) r0 = k; else if (reads == 1) r1 = k;
            reads++;
         end
      end
      fifo_empty = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (t[r0+2+i] !== e0[i/4]) bad0++;
         if (t[r0+44+i] !== e1[i/4]) bad1++;
      end
      checks++; if (reads != 2) begin failures++; $display("FAIL b2b_reads got=%0d exp=2", reads); end
      checks++; if (r1 - r0 != 42) begin failures++; $display("FAIL b2b_rd_spacing got=%0d exp=42", r1 - r0); end
      checks++; if (t[r0+42] !== 1'b1 || t[r0+43] !== 1'b1 || t[r0+44] !== 1'b0)
         begin failures++; $display("FAIL b2b_gap got=%b%b%b exp=110", t[r0+42], t[r0+43], t[r0+44]); end
      checks++; if (bad0 != 0) begin failures++; $display("FAIL b2b_frame_00 bad=%0d exp=0", bad0); end
      checks++; if (bad1 != 0) begin failures++; $display("FAIL b2b_frame_ff bad=%0d exp=0", bad1); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
   endtask

   task automatic test_param_sweep();
      logic [5:0] pt; int bsy = 0;
      logic [5:0] e = 6'b111100;       // 0,0,1,1,1,1 from index 0
      @(negedge clk); p_rdata = 1'b1; p_empty = 1'b0;
      #1;
      checks++; if (p_rd_en !== 1'b1) begin failures++; $display("FAIL sweep_rd_en got=%b exp=1", p_rd_en); end
      @(negedge clk); p_empty = 1'b1;
      #1;
      checks++; if (p_tx !== 1'b1 || p_busy !== 1'b1) begin failures++; $display("FAIL sweep_fetch tx=%b busy=%b exp 1/1", p_tx, p_busy); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1 pt[i] = p_tx; bsy += int'(p_busy);
      end
      checks++; if (pt !== e) begin failures++; $display("FAIL sweep_frame got=%b exp=%b", pt, e); end
      checks++; if (bsy != 6) begin failures++; $display("FAIL sweep_busy got=%0d exp=6", bsy); end
      @(negedge clk); #1;
      checks++; if (p_busy !== 1'b0 || p_tx !== 1'b1) begin failures++; $display("FAIL sweep_end busy=%b tx=%b exp 0/1", p_busy, p_tx); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_idle_empty();
      test_reset_mid();
      test_rdata_change();
      test_param_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame (legal range 1..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port fifo_rdata, input, DATA_WIDTH, read data from the upstream FIFO, valid the cycle after an accepted read.
REQ-006 SHALL have port fifo_empty, input, 1, upstream FIFO empty flag.
REQ-007 SHALL have port fifo_rd_en, output, 1, read strobe to the upstream FIFO.
REQ-008 SHALL have port tx, output, 1, serial line (idle high).
REQ-009 SHALL have port busy, output, 1, high whenever a frame fetch or transmission is in progress.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, START, DATA, STOP.
REQ-011 fifo_rd_en SHALL be combinational: high only when state==IDLE and fifo_empty==0; never high in any other state.
REQ-012 IDLE -> FETCH on any cycle fifo_rd_en is high; otherwise remain IDLE.
REQ-013 FETCH SHALL last exactly 1 cycle, load fifo_rdata into a DATA_WIDTH shift register, then go to START.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after FETCH.
REQ-015 DATA: DATA_WIDTH bits, LSB first, each held on tx for exactly CLKS_PER_BIT cycles; bit index counter from 0 to DATA_WIDTH-1.
REQ-016 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then go to IDLE.
REQ-017 tx SHALL be driven from a register (glitch-free); tx=1 in IDLE and FETCH.
REQ-018 Baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, clear on every state change; no wrap artefacts for any legal CLKS_PER_BIT.
REQ-019 Total frame SHALL occupy exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles of tx activity.
REQ-020 Back-to-back frames: after STOP, with fifo_empty==0, one IDLE cycle (fifo_rd_en high) plus one FETCH cycle SHALL precede the next START; tx stays 1 for those 2 cycles.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 Changes of fifo_empty or fifo_rdata outside IDLE/FETCH SHALL have no effect on the frame in progress.
REQ-023 Exactly one FIFO read per frame; no read while fifo_empty==1.

Reset
REQ-024 While rst_n==0: state=IDLE, tx=1, busy=0, fifo_rd_en=0, counters and shift register 0, all asynchronously.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 in the same cycle); the aborted word is not retransmitted.
REQ-026 First fifo_rd_en after reset SHALL occur no earlier than the first rising edge following rst_n deassertion with fifo_empty==0.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-027 Single word 0xA5, fifo_empty falls -> fifo_rd_en 1 cycle; tx after FETCH = 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 cycles); busy high 41 cycles; returns IDLE.
REQ-028 Two words 0x00, 0xFF queued -> two fifo_rd_en pulses 42 cycles apart; tx high exactly 2 cycles between first STOP end and second start bit.
REQ-029 fifo_empty held 1 for 100 cycles -> fifo_rd_en never asserted, tx=1, busy=0 throughout.
REQ-030 Reset asserted during DATA bit 3 of 0x3C -> tx=1, busy=0 immediately; after release with fifo_empty==0, next word transmits as a complete, correct frame.
REQ-031 fifo_rdata toggled to 0x55 during DATA of frame 0x81 -> serialized bits still match 0x81.
REQ-032 Parameter sweep CLKS_PER_BIT=2 and DATA_WIDTH=1 with word 1 -> tx = 0,0,1,1,1,1 after FETCH; frame length 6 cycles.
